gate_test_sequencer: RTL and testbench

Self-checking stimulus controller for a 2-input combinational gate (e.g. `and_gate`). On `start`, it sweeps every input combination onto the gate, waits a programmable settle time, samples the gate output and compares it against a truth-table parameter. It accumulates the errors and reports pass/fail. It sits between bring-up control logic and the gate under test, so gate verification can run on-chip and in simulation without a hand-written vector list.

---
 rtl/gate_test_sequencer.sv | 158 +++++++++++++++
 tb/tb_gate_test_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_test_sequencer.sv
// Self-checking stimulus controller for a 2-input combinational gate: sweeps
// all four input vectors, samples the gate after a settle time and tallies mismatches.
module gate_test_sequencer #(
    parameter logic [3:0] TRUTH_TABLE = 4'b1000,
    parameter int         SETTLE      = 2,
    parameter int         PASSES      = 1,
    parameter int         CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             dut_c,
    output logic             dut_a,
    output logic             dut_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       first_fail,
    output logic             first_fail_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [7:0]       PASS_LAST   = 8'(PASSES - 1);
    localparam logic [CNT_W-1:0] ERR_MAX     = '1;

    state_t           state, state_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [7:0]       pass_cnt, pass_cnt_nxt;
    logic [7:0]       settle_cnt, settle_cnt_nxt;
    logic             a_nxt, b_nxt;
    logic             pass_nxt;
    logic [CNT_W-1:0] err_nxt;
    logic [1:0]       ff_nxt;
    logic             ffv_nxt;

    assign busy = (state == S_SETTLE) || (state == S_CHECK);
    assign done = (state == S_DONE);

    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        pass_cnt_nxt   = pass_cnt;
        settle_cnt_nxt = settle_cnt;
        a_nxt          = dut_a;
        b_nxt          = dut_b;
        pass_nxt       = pass;
        err_nxt        = err_count;
        ff_nxt         = first_fail;
        ffv_nxt        = first_fail_valid;

        case (state)
            S_IDLE: begin
                if (start) begin
                    err_nxt        = '0;
                    pass_nxt       = 1'b0;
                    ff_nxt         = 2'b00;
                    ffv_nxt        = 1'b0;
                    idx_nxt        = 2'd0;
                    pass_cnt_nxt   = 8'd0;
                    settle_cnt_nxt = 8'd0;
                    a_nxt          = 1'b0;
                    b_nxt          = 1'b0;
                    state_nxt      = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    pass_nxt  = 1'b0;
                    a_nxt     = 1'b0;
                    b_nxt     = 1'b0;
                    state_nxt = S_IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = S_CHECK;
                end else begin
                    settle_cnt_nxt = settle_cnt + 8'd1;
                end
            end
            S_CHECK: begin
                // An abort here discards this cycle's comparison entirely.
                if (abort) begin
                    pass_nxt  = 1'b0;
                    a_nxt     = 1'b0;
                    b_nxt     = 1'b0;
                    state_nxt = S_IDLE;
                end else begin
                    if (dut_c != TRUTH_TABLE[idx]) begin
                        if (err_count != ERR_MAX) begin
                            err_nxt = err_count + 1'b1;
                        end
                        if (!first_fail_valid) begin
                            ff_nxt  = idx;
                            ffv_nxt = 1'b1;
                        end
                    end
                    if (idx != 2'd3) begin
                        idx_nxt          = idx + 2'd1;
                        {a_nxt, b_nxt}   = idx + 2'd1;
                        settle_cnt_nxt   = 8'd0;
                        state_nxt        = S_SETTLE;
                    end else if (pass_cnt != PASS_LAST) begin
                        pass_cnt_nxt   = pass_cnt + 8'd1;
                        idx_nxt        = 2'd0;
                        a_nxt          = 1'b0;
                        b_nxt          = 1'b0;
                        settle_cnt_nxt = 8'd0;
                        state_nxt      = S_SETTLE;
                    end else begin
                        // pass must already be valid during the DONE cycle
                        pass_nxt  = (err_nxt == '0);
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            idx              <= 2'd0;
            pass_cnt         <= 8'd0;
            settle_cnt       <= 8'd0;
            dut_a            <= 1'b0;
            dut_b            <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail       <= 2'b00;
            first_fail_valid <= 1'b0;
        end else begin
            state            <= state_nxt;
            idx              <= idx_nxt;
            pass_cnt         <= pass_cnt_nxt;
            settle_cnt       <= settle_cnt_nxt;
            dut_a            <= a_nxt;
            dut_b            <= b_nxt;
            pass             <= pass_nxt;
            err_count        <= err_nxt;
            first_fail       <= ff_nxt;
            first_fail_valid <= ffv_nxt;
        end
    end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Bench for gate_test_sequencer: three parameterisations driven by a random
// gate function, checked against a sweep-level arithmetic model.
module tb_gate_test_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start = 3'b000;
    logic [2:0] abort = 3'b000;
    logic [2:0] c, a, b, busy, done, pass, ffv;
    logic [3:0] err0, err2;
    logic [1:0] err1;
    logic [1:0] ff0, ff1, ff2;
    logic [3:0] fn [3];

    int checks = 0;
    int errors = 0;

    logic [1:0] sel = 2'd0;
    logic       o_busy, o_done, o_pass, o_ffv, o_a, o_b;
    logic [3:0] o_err;
    logic [1:0] o_ff;

    always #5 clk = ~clk;

    assign c[0] = fn[0][{a[0], b[0]}];
    assign c[1] = fn[1][{a[1], b[1]}];
    assign c[2] = fn[2][{a[2], b[2]}];

    gate_test_sequencer #(.TRUTH_TABLE(4'b1000), .SETTLE(2), .PASSES(1), .CNT_W(4)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .dut_c(c[0]),
        .dut_a(a[0]), .dut_b(b[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(err0), .first_fail(ff0), .first_fail_valid(ffv[0]));

    gate_test_sequencer #(.TRUTH_TABLE(4'b1000), .SETTLE(2), .PASSES(3), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .dut_c(c[1]),
        .dut_a(a[1]), .dut_b(b[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(err1), .first_fail(ff1), .first_fail_valid(ffv[1]));

    gate_test_sequencer #(.TRUTH_TABLE(4'b0110), .SETTLE(1), .PASSES(1), .CNT_W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]), .dut_c(c[2]),
        .dut_a(a[2]), .dut_b(b[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .err_count(err2), .first_fail(ff2), .first_fail_valid(ffv[2]));

    always_comb begin
        o_busy = busy[sel];
        o_done = done[sel];
        o_pass = pass[sel];
        o_ffv  = ffv[sel];
        o_a    = a[sel];
        o_b    = b[sel];
        case (sel)
            2'd0:    begin o_err = err0;          o_ff = ff0; end
            2'd1:    begin o_err = {2'b00, err1}; o_ff = ff1; end
            default: begin o_err = err2;          o_ff = ff2; end
        endcase
    end

    function automatic int settle_of(input int s);
        return (s == 2) ? 1 : 2;
    endfunction

    function automatic int passes_of(input int s);
        return (s == 1) ? 3 : 1;
    endfunction

    function automatic int errmax_of(input int s);
        return (s == 1) ? 3 : 15;
    endfunction

    function automatic logic [3:0] table_of(input int s);
        return (s == 2) ? 4'b0110 : 4'b1000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch a run on instance s with gate function f and check it end to end.
    // A stray start is injected during busy cycle extra (negative: none).
    task automatic do_run(input int s, input logic [3:0] f, input int extra, input string name);
        int st, np, n, pc, exp_err, cnt, vec_bad, done_bad, first;
        logic [3:0] mism;
        st = settle_of(s);
        np = passes_of(s);
        n = np * 4 * (st + 1);
        mism = f ^ table_of(s);
        pc = 0;
        first = -1;
        for (int i = 0; i < 4; i++) begin
            if (mism[i]) begin
                pc++;
                if (first < 0) first = i;
            end
        end
        exp_err = (np * pc > errmax_of(s)) ? errmax_of(s) : np * pc;
        sel = 2'(s);
        fn[s] = f;
        start[s] = 1'b1;
        tick();
        start[s] = 1'b0;
        cnt = 0;
        vec_bad = 0;
        done_bad = 0;
        while (o_busy && cnt < n + 20) begin
            if ({o_a, o_b} !== 2'((cnt / (st + 1)) % 4)) vec_bad++;
            if (o_done !== 1'b0) done_bad++;
            start[s] = (cnt == extra);
            cnt++;
            tick();
        end
        start[s] = 1'b0;
        checks++;
        if (cnt != n) begin
            errors++;
            $display("FAIL %s busy_len got %0d want %0d", name, cnt, n);
        end
        checks++;
        if (vec_bad != 0 || done_bad != 0) begin
            errors++;
            $display("FAIL %s vector_order bad_vectors %0d early_done %0d want 0 0", name, vec_bad, done_bad);
        end
        checks++;
        if (o_done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_pulse got %b want 1", name, o_done);
        end
        checks++;
        if (o_pass !== (exp_err == 0) || o_err !== 4'(exp_err)) begin
            errors++;
            $display("FAIL %s result pass/err got %b/%0d want %b/%0d", name, o_pass, o_err, exp_err == 0, exp_err);
        end
        checks++;
        if (o_ffv !== (first >= 0) || (first >= 0 && o_ff !== 2'(first))) begin
            errors++;
            $display("FAIL %s first_fail got v%b ff%b want v%b ff%0d", name, o_ffv, o_ff, first >= 0, first);
        end
        tick();
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_pass !== (exp_err == 0)) begin
            errors++;
            $display("FAIL %s after_done done/busy/pass got %b%b%b want 00%b", name, o_done, o_busy, o_pass, exp_err == 0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            checks++;
            if ({o_busy, o_done, o_pass, o_ffv, o_a, o_b, o_err, o_ff} !== 12'd0) begin
                errors++;
                $display("FAIL reset_state inst%0d got %b want all zero", s,
                         {o_busy, o_done, o_pass, o_ffv, o_a, o_b, o_err, o_ff});
            end
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_and();
        do_run(0, 4'b1000, -1, "ideal_and");
    endtask

    task automatic test_faulty();
        do_run(0, 4'b1110, -1, "faulty_or");
    endtask

    task automatic test_saturation();
        do_run(1, 4'b1111, -1, "saturation");
    endtask

    task automatic test_xor();
        do_run(2, 4'b0110, -1, "xor_table");
    endtask

    task automatic test_ignored_start();
        do_run(0, 4'b1000, 4, "ignored_start");
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            int s;
            s = int'($urandom_range(2, 0));
            do_run(s, 4'($urandom), int'($urandom_range(20, 0)) - 4, "random_run");
            repeat ($urandom_range(2, 0)) tick();
        end
    endtask

    task automatic test_abort();
        for (int k = 0; k < 5; k++) begin
            int r, cnt, exp_err, first;
            logic [3:0] f, mism;
            r = (k == 0) ? 5 : int'($urandom_range(11, 0));
            f = (k == 0) ? 4'b1111 : 4'($urandom);
            mism = f ^ 4'b1000;
            exp_err = 0;
            first = -1;
            for (int v = 0; v < 4; v++) begin
                if (v * 3 + 2 < r && mism[v]) begin
                    exp_err++;
                    if (first < 0) first = v;
                end
            end
            sel = 2'd0;
            fn[0] = f;
            start[0] = 1'b1;
            abort[0] = 1'b1;
            tick();
            start[0] = 1'b0;
            abort[0] = 1'b0;
            checks++;
            if (o_busy !== 1'b1) begin
                errors++;
                $display("FAIL start_beats_abort busy got %b want 1", o_busy);
            end
            cnt = 0;
            while (cnt < r && o_busy) begin
                cnt++;
                tick();
            end
            abort[0] = 1'b1;
            tick();
            abort[0] = 1'b0;
            checks++;
            if ({o_busy, o_done, o_pass, o_a, o_b} !== 5'd0 || o_err !== 4'(exp_err)) begin
                errors++;
                $display("FAIL abort_at_%0d busy/done/pass/a/b err got %b %0d want 00000 %0d", r,
                         {o_busy, o_done, o_pass, o_a, o_b}, o_err, exp_err);
            end
            checks++;
            if (o_ffv !== (first >= 0) || (first >= 0 && o_ff !== 2'(first))) begin
                errors++;
                $display("FAIL abort_first_fail got v%b ff%b want v%b ff%0d", o_ffv, o_ff, first >= 0, first);
            end
            tick();
            checks++;
            if (o_done !== 1'b0 || o_busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done done/busy got %b%b want 00", o_done, o_busy);
            end
        end
    endtask

    task automatic test_reset_midrun();
        sel = 2'd0;
        fn[0] = 4'b1111;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (4) tick();
        checks++;
        if (o_busy !== 1'b1 || {o_a, o_b} !== 2'b01 || o_err !== 4'd1) begin
            errors++;
            $display("FAIL pre_reset busy/ab/err got %b %b %0d want 1 01 1", o_busy, {o_a, o_b}, o_err);
        end
        rst_n = 1'b0;
        start[0] = 1'b1;
        abort[0] = 1'b1;
        tick();
        checks++;
        if ({o_busy, o_done, o_pass, o_ffv, o_a, o_b, o_err, o_ff} !== 12'd0) begin
            errors++;
            $display("FAIL reset_midrun got %b want all zero",
                     {o_busy, o_done, o_pass, o_ffv, o_a, o_b, o_err, o_ff});
        end
        rst_n = 1'b1;
        start[0] = 1'b0;
        abort[0] = 1'b0;
        tick();
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_stays_idle busy got %b want 0", o_busy);
        end
    endtask

    task automatic test_back_to_back();
        int cnt;
        sel = 2'd0;
        fn[0] = 4'b1000;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        cnt = 0;
        while (o_busy && cnt < 40) begin
            cnt++;
            tick();
        end
        start[0] = 1'b1;
        tick();
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done busy/done got %b%b want 00", o_busy, o_done);
        end
        tick();
        start[0] = 1'b0;
        checks++;
        if (o_busy !== 1'b1 || {o_a, o_b} !== 2'b00) begin
            errors++;
            $display("FAIL relaunch busy/ab got %b %b want 1 00", o_busy, {o_a, o_b});
        end
        cnt = 0;
        while (o_busy && cnt < 40) begin
            cnt++;
            tick();
        end
        checks++;
        if (cnt != 12 || o_done !== 1'b1 || o_pass !== 1'b1) begin
            errors++;
            $display("FAIL relaunch_run len/done/pass got %0d %b %b want 12 1 1", cnt, o_done, o_pass);
        end
        tick();
    endtask

    initial begin
        fn[0] = 4'b1000;
        fn[1] = 4'b1000;
        fn[2] = 4'b0110;
        test_reset();
        test_and();
        test_faulty();
        test_saturation();
        test_xor();
        test_ignored_start();
        test_abort();
        test_reset_midrun();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
